// File: rtl/bt_encoder_tx.sv
// Bluetooth HID return path: paint events are queued in a small FIFO, framed and sent 8N1 on tx.
// Build option: define CHECKSUM_EN to append an XOR checksum byte (B1^B2^B3) to every frame.
module bt_encoder_tx #(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         BAUD_RATE  = 9600,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hAA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] in_cmd,
    input  logic [5:0] in_x,
    input  logic [5:0] in_y,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       drop_flag
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef CHECKSUM_EN
    localparam logic [2:0] LAST = 3'd4;
`else
    localparam logic [2:0] LAST = 3'd3;
`endif
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ZERO_CNT = (AW+1)'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

`ifdef CHECKSUM_EN
    function automatic logic [7:0] checksum(input logic [7:0] b1, input logic [7:0] b2,
                                            input logic [7:0] b3);
        return b1 ^ b2 ^ b3;
    endfunction
`endif

    // Event word layout is {cmd, x, y}; index 0 and anything unused map to the sync byte.
    function automatic logic [7:0] frame_byte(input logic [14:0] evt, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd1:    b = {5'b00000, evt[14:12]};
            3'd2:    b = {2'b00, evt[11:6]};
            3'd3:    b = {2'b00, evt[5:0]};
`ifdef CHECKSUM_EN
            3'd4:    b = checksum({5'b00000, evt[14:12]}, {2'b00, evt[11:6]}, {2'b00, evt[5:0]});
`endif
            default: b = SYNC_BYTE;
        endcase
        return b;
    endfunction

    logic [14:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r, count_s;
    logic          push_s, pop_s;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [2:0]    byte_idx_r, byte_idx_s;
    logic [7:0]    shift_r, shift_s;
    logic [14:0]   evt_r, evt_s;
    logic          done_s, tx_s, bit_end_s, fifo_avail_s;

    logic          tx_r, in_ready_r, busy_r, frame_done_r, drop_r;

    assign push_s       = in_valid & in_ready_r;
    assign fifo_avail_s = (count_r != ZERO_CNT);
    assign bit_end_s    = (cnt_r == BIT_END);

    // FIFO occupancy for the next cycle; a refused push never reaches this logic.
    always_comb begin
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + (AW+1)'(1);
        end else if (!push_s && pop_s) begin
            count_s = count_r - (AW+1)'(1);
        end else begin
            count_s = count_r;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_cmd, in_x, in_y};
        end
    end

    // Framing FSM: next state, bit/byte counters and the serial level for the next cycle.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_idx_s  = bit_idx_r;
        byte_idx_s = byte_idx_r;
        shift_s    = shift_r;
        evt_s      = evt_r;
        pop_s      = 1'b0;
        done_s     = 1'b0;
        tx_s       = 1'b1;
        case (state_r)
            IDLE: begin
                tx_s = 1'b1;
                if (fifo_avail_s) begin
                    pop_s      = 1'b1;
                    evt_s      = mem_r[rd_ptr_r];
                    byte_idx_s = 3'd0;
                    shift_s    = SYNC_BYTE;
                    cnt_s      = '0;
                    state_s    = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                tx_s = 1'b0;
                if (bit_end_s) begin
                    cnt_s     = '0;
                    bit_idx_s = 3'd0;
                    state_s   = DATA;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            DATA: begin
                tx_s = shift_r[0];
                if (bit_end_s) begin
                    cnt_s   = '0;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            STOP: begin
                tx_s = 1'b1;
                if (bit_end_s) begin
                    cnt_s = '0;
                    if (byte_idx_r == LAST) begin
                        done_s = 1'b1;
                        // Chain straight into the next frame so no idle bit appears between frames.
                        if (fifo_avail_s) begin
                            pop_s      = 1'b1;
                            evt_s      = mem_r[rd_ptr_r];
                            byte_idx_s = 3'd0;
                            shift_s    = SYNC_BYTE;
                            state_s    = START;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        byte_idx_s = byte_idx_r + 3'd1;
                        shift_s    = frame_byte(evt_r, byte_idx_r + 3'd1);
                        state_s    = START;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            byte_idx_r   <= 3'd0;
            shift_r      <= 8'h00;
            evt_r        <= 15'h0000;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= ZERO_CNT;
            tx_r         <= 1'b1;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            drop_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            bit_idx_r    <= bit_idx_s;
            byte_idx_r   <= byte_idx_s;
            shift_r      <= shift_s;
            evt_r        <= evt_s;
            wr_ptr_r     <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            rd_ptr_r     <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
            count_r      <= count_s;
            tx_r         <= tx_s;
            in_ready_r   <= (count_s != FULL_CNT);
            busy_r       <= fifo_avail_s || (state_r != IDLE);
            frame_done_r <= done_s;
            drop_r       <= drop_r | (in_valid & ~in_ready_r);
        end
    end

    assign tx         = tx_r;
    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign drop_flag  = drop_r;

endmodule
